// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared types and constants for the FND up-counter control unit.
//   - state_e : STOP/RUN/CLEAR encoding (also the o_state encoding)
//   - COUNT_W : count width (fixed at 14 bits, max 16383)
//   - count_inc : wrap-around increment helper
package counter_ctrl_pkg;

    localparam int unsigned COUNT_W = 14;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    // Increment with wrap to zero; any value at or above max wraps, so the count never exceeds max.
    function automatic logic [COUNT_W-1:0] count_inc(
        input logic [COUNT_W-1:0] cur,
        input logic [COUNT_W-1:0] max
    );
        return (cur >= max) ? '0 : cur + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/counter_ctrl_unit_btn_edge_detector.sv
// btn_edge_detector: turns a raw asynchronous push-button into a one-cycle press pulse.
//   2-FF synchronizer -> (optional debounce) -> rising-edge detector.
//   Optional debounce is enabled by defining BTN_DEBOUNCE_EN: the synchronized level is
//   accepted only after DB_CYCLES consecutive identical samples.
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous active-low reset
//   i_btn    in  raw button, active-high, asynchronous to clk
//   o_pulse  out one-cycle registered press pulse
module btn_edge_detector #(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_pulse
);

    // Zero stable samples would never accept a level.
    if (DB_CYCLES == 0) begin : g_bad_db_cycles
        $error("btn_edge_detector: DB_CYCLES must be at least 1");
    end

    logic [1:0] r_sync;
    logic       r_prev;
    logic       r_pulse;
    logic       w_level;

    // Two-stage synchronizer for the asynchronous button.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            r_db_level;
    logic [DB_W-1:0] r_db_cnt;

    // Count consecutive samples that differ from the accepted level; accept on the DB_CYCLES-th.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_db_level <= 1'b0;
            r_db_cnt   <= '0;
        end else if (r_sync[1] == r_db_level) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_db_level <= r_sync[1];
            r_db_cnt   <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
        end
    end

    assign w_level = r_db_level;
`else
    assign w_level = r_sync[1];
`endif

    // Rising-edge detect: one pulse per press however long the button is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= w_level;
            r_pulse <= w_level & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/counter_ctrl_unit.sv
// counter_ctrl_unit: run/stop/clear control for the 4-digit FND up-counter.
//   Buttons -> press pulses -> STOP/RUN/CLEAR FSM; tick divider and 0..COUNT_MAX counter.
//   Optional button debounce: define BTN_DEBOUNCE_EN (uses DB_CYCLES).
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   i_btn_run    in   raw run/stop button, active-high
//   i_btn_clear  in   raw clear button, active-high
//   o_count      out  current count, binary, 0..COUNT_MAX
//   o_run        out  high while in RUN
//   o_tick       out  one-cycle pulse with each newly incremented count
//   o_state      out  STOP=0, RUN=1, CLEAR=2
module counter_ctrl_unit
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned TICK_HZ   = 10,
    parameter int unsigned COUNT_MAX = 9999,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_btn_run,
    input  logic               i_btn_clear,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_run,
    output logic               o_tick,
    output logic [STATE_W-1:0] o_state
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX  = COUNT_W'(COUNT_MAX);

    if (TICK_DIV < 2 || COUNT_MAX > 16383) begin : g_bad_cfg
        $error("counter_ctrl_unit: need CLK_HZ/TICK_HZ >= 2 and COUNT_MAX <= 16383");
    end

    logic w_run_p;
    logic w_clear_p;

    state_e             r_state;
    state_e             w_state_nxt;
    logic               r_run;
    logic               r_tick;
    logic [DIV_W-1:0]   r_div;
    logic [COUNT_W-1:0] r_count;

    btn_edge_detector #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_run (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (i_btn_run),
        .o_pulse (w_run_p)
    );

    btn_edge_detector #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_clear (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (i_btn_clear),
        .o_pulse (w_clear_p)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: clear beats run in STOP, clear is ignored in RUN, CLEAR is a single cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_STOP: begin
                if (w_clear_p) begin
                    w_state_nxt = ST_CLEAR;
                end else if (w_run_p) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_run_p) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_CLEAR: begin
                w_state_nxt = ST_STOP;
            end
            default: begin
                w_state_nxt = ST_STOP;
            end
        endcase
    end

    // Registered run flag tracks the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run <= 1'b0;
        end else begin
            r_run <= (w_state_nxt == ST_RUN);
        end
    end

    // Divider and counter act on the current state, so a stop press on a wrap cycle still counts.
    // The divider holds in STOP so a resume keeps its phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div   <= '0;
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (r_div == DIV_LAST) begin
                        r_div   <= '0;
                        r_count <= count_inc(r_count, CNT_MAX);
                        r_tick  <= 1'b1;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                ST_CLEAR: begin
                    r_div   <= '0;
                    r_count <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_count = r_count;
    assign o_run   = r_run;
    assign o_tick  = r_tick;
    assign o_state = r_state;

endmodule
